mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multiply/divide unit with HI/LO registers; MUL_DIV_FAST_MUL_EN selects single-cycle multiply
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0]    OP_MTHI = 3'b100;
  localparam logic [2:0]    OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     a_raw;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 b_zero;

  logic                 accept;
  logic                 arith_req;
  logic                 signed_req;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a_in;
  logic [WIDTH-1:0]     mag_b_in;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;

  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;

  // Requests are only taken while idle; ops with op[2]=1 never start the engine.
  assign accept     = start && (state == IDLE);
  assign arith_req  = accept && !op[2];
  assign signed_req = !op[0];
  assign sign_a     = signed_req && A[WIDTH-1];
  assign sign_b     = signed_req && B[WIDTH-1];
  assign mag_a_in   = sign_a ? -A : A;
  assign mag_b_in   = sign_b ? -B : B;

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: remainder in the upper half, dividend/quotient shifting through the lower half.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b;
  assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  // Sign fix-up applied in FIX on the unsigned magnitude result.
  assign prod = neg_res ? -acc : acc;
  assign quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a_in} * {{WIDTH{1'b0}}, mag_b_in};
`endif

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> CALC (WIDTH edges) -> FIX -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arith_req) begin
`ifdef MUL_DIV_FAST_MUL_EN
          state_nxt = op[1] ? CALC : FIX;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag write-back at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mag_b    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi <= A;
            end else if (op == OP_MTLO) begin
              lo <= A;
            end else if (!op[2]) begin
              acc <= {{WIDTH{1'b0}}, mag_a_in};
`ifdef MUL_DIV_FAST_MUL_EN
              if (!op[1]) acc <= fast_prod;
`endif
              mag_b   <= mag_b_in;
              a_raw   <= A;
              is_div  <= op[1];
              neg_res <= sign_a ^ sign_b;
              neg_rem <= sign_a;
              b_zero  <= (B == '0);
              cnt     <= '0;
            end
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_div && b_zero) begin
            lo       <= '1;
            hi       <= a_raw;
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo       <= quot;
            hi       <= rem;
            div_zero <= 1'b0;
          end else begin
            hi       <= prod[2*WIDTH-1:WIDTH];
            lo       <= prod[WIDTH-1:0];
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit (table vectors, corner sequences, random vs model)
module tb_mul_div_unit;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  localparam int DIV_LAT = 33;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on wide integers; returns {dz, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     v;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      MULT:  begin v = sa * sb; return {1'b0, v}; end
      MULTU: begin p = ua * ub; return {1'b0, p}; end
      DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input bit b2b);
    int          lat, cyc;
    logic [31:0] h0, l0;
    bit          hold_ok, seen;
    lat = o[1] ? DIV_LAT : MUL_LAT;
    if (!b2b) begin
      @(negedge clk);
      check({name, " done_pulse_cleared"}, {63'd0, done}, 64'd0);
    end
    h0 = hi;
    l0 = lo;
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hold_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) cyc++;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      @(negedge clk);
    end
    check({name, " done_seen"}, {63'd0, seen}, 64'd1);
    check({name, " busy_cycles"}, 64'(cyc), 64'(lat));
    check({name, " hilo_hold"}, {63'd0, hold_ok}, 64'd1);
    check({name, " busy_at_done"}, {63'd0, busy}, 64'd0);
    check({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
    check({name, " lo"}, {32'd0, lo}, {32'd0, elo});
    check({name, " div_zero"}, {63'd0, div_zero}, {63'd0, edz});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl[10];
  logic [64:0] m;
  logic [31:0] ra, rb, h0, l0;
  logic [2:0]  ro;
  bit          seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
    tbl[0] = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[4] = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    tbl[5] = '{MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    tbl[6] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[7] = '{DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    tbl[8] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[9] = '{DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};

    #12;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset div_zero", {63'd0, div_zero}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].ehi, tbl[i].elo, tbl[i].edz, (i % 2) == 1);

    // MTHI leaves div_zero alone and raises neither busy nor done.
    do_op("divu_by_zero", DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; op = MTHI; A = 32'h0000CAFE;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", {32'd0, hi}, 64'h0000CAFE);
    check("mthi div_zero", {63'd0, div_zero}, 64'd1);
    check("mthi busy", {63'd0, busy}, 64'd0);
    check("mthi done", {63'd0, done}, 64'd0);

    // Reserved op: no state change, no done.
    h0 = hi; l0 = lo;
    start = 1'b1; op = 3'b110; A = 32'h12345678; B = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("reserved busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("reserved done", {63'd0, done}, 64'd0);
    check("reserved hi", {32'd0, hi}, {32'd0, h0});
    check("reserved lo", {32'd0, lo}, {32'd0, l0});

    // Requests while busy are ignored.
    start = 1'b1; op = DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = MULT; A = 32'd3; B = 32'd3;
    @(negedge clk);
    op = MTHI; A = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    check("ignored busy", {63'd0, busy}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("ignored done_seen", {63'd0, seen}, 64'd1);
    check("ignored lo", {32'd0, lo}, 64'h0000000E);
    check("ignored hi", {32'd0, hi}, 64'h00000002);

    // Reset mid-operation, then accept on the first edge after release.
    @(negedge clk);
    start = 1'b1; op = DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst hi", {32'd0, hi}, 64'd0);
    check("midrst lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; op = MTLO; A = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", {32'd0, lo}, 64'h00001234);
    check("mtlo busy", {63'd0, busy}, 64'd0);
    check("mtlo done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("mtlo done_later", {63'd0, done}, 64'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      m  = model(ro, ra, rb);
      do_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb,
            m[63:32], m[31:0], m[64], $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
